// File: rtl/crack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : crack_ctrl
//  Purpose  : Brute-force key-search sequencer for one arc4 decryption core.
//             Steps a candidate key, launches arc4 once per key, then scans
//             the decrypted message in pt_mem (byte 0 = length). It stops on
//             the first key whose plaintext is entirely printable, or when
//             KEY_LAST has been tried without success.
//  Ports    : clk, rst_n             clock, asynchronous active-low reset
//             en / rdy               start handshake (en honoured while rdy=1)
//             key / key_valid        candidate or found key, search result
//             a4_en / a4_rdy         arc4 start pulse and ready
//             a4_pt_addr/wrdata/wren arc4 side of the pt_mem port
//             pt_addr/wrdata/wren    muxed pt_mem port
//             pt_rddata              pt_mem read data (1-cycle latency)
//  Revision : 1.0  initial release
// ============================================================================
module crack_ctrl #(
   parameter int               KEY_W     = 24,
   parameter logic [KEY_W-1:0] KEY_FIRST = '0,
   parameter logic [KEY_W-1:0] KEY_STEP  = {{(KEY_W-1){1'b0}}, 1'b1},
   parameter logic [KEY_W-1:0] KEY_LAST  = '1,
   parameter logic [7:0]       CH_LO     = 8'h20,
   parameter logic [7:0]       CH_HI     = 8'h7E
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic             rdy,
   output logic [KEY_W-1:0] key,
   output logic             key_valid,
   output logic             a4_en,
   input  logic             a4_rdy,
   input  logic [7:0]       a4_pt_addr,
   input  logic [7:0]       a4_pt_wrdata,
   input  logic             a4_pt_wren,
   output logic [7:0]       pt_addr,
   output logic [7:0]       pt_wrdata,
   output logic             pt_wren,
   input  logic [7:0]       pt_rddata
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LAUNCH   = 3'd1,
      S_RUN      = 3'd2,
      S_SCAN_LEN = 3'd3,
      S_SCAN     = 3'd4
   } state_t;

   state_t           r_state;
   logic [KEY_W-1:0] r_key;
   logic             r_rdy;
   logic             r_key_valid;
   logic             r_a4_en;
   logic [7:0]       r_scan_addr;   // address the scanner presents to pt_mem
   logic [7:0]       r_len;         // message length latched from byte 0
   logic [7:0]       r_idx;         // index of the byte arriving on pt_rddata
   logic [1:0]       r_skip;        // cycles of a4_rdy to ignore after a4_en
   logic             r_len_phase;   // 0: address 0 issued, 1: length arriving

   logic             w_arc4_owns;
   logic             w_byte_ok;

   // arc4 owns the memory port only while it is launching or decrypting
   assign w_arc4_owns = (r_state == S_LAUNCH) || (r_state == S_RUN);
   assign w_byte_ok   = (pt_rddata >= CH_LO) && (pt_rddata <= CH_HI);

   assign pt_addr   = w_arc4_owns ? a4_pt_addr : r_scan_addr;
   assign pt_wrdata = a4_pt_wrdata;
   // r_state resets asynchronously, so the write enable drops with rst_n
   assign pt_wren   = w_arc4_owns & a4_pt_wren;

   assign rdy       = r_rdy;
   assign key       = r_key;
   assign key_valid = r_key_valid;
   assign a4_en     = r_a4_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_key       <= KEY_FIRST;
         r_rdy       <= 1'b1;
         r_key_valid <= 1'b0;
         r_a4_en     <= 1'b0;
         r_scan_addr <= 8'd0;
         r_len       <= 8'd0;
         r_idx       <= 8'd0;
         r_skip      <= 2'd0;
         r_len_phase <= 1'b0;
      end else begin
         r_a4_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (en) begin
                  r_key       <= KEY_FIRST;
                  r_key_valid <= 1'b0;
                  r_rdy       <= 1'b0;
                  r_state     <= S_LAUNCH;
               end
            end

            S_LAUNCH: begin
               if (a4_rdy) begin
                  r_a4_en <= 1'b1;
                  // a4_rdy is stale in the pulse cycle and the one after it
                  r_skip  <= 2'd2;
                  r_state <= S_RUN;
               end
            end

            S_RUN: begin
               if (r_skip != 2'd0) begin
                  r_skip <= r_skip - 2'd1;
               end else if (a4_rdy) begin
                  r_scan_addr <= 8'd0;
                  r_len_phase <= 1'b0;
                  r_state     <= S_SCAN_LEN;
               end
            end

            S_SCAN_LEN: begin
               if (!r_len_phase) begin
                  r_len_phase <= 1'b1;
                  r_scan_addr <= 8'd1;
               end else if (pt_rddata == 8'd0) begin
                  // empty message counts as printable
                  r_key_valid <= 1'b1;
                  r_rdy       <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_len       <= pt_rddata;
                  r_idx       <= 8'd1;
                  r_scan_addr <= (pt_rddata == 8'd1) ? 8'd1 : 8'd2;
                  r_state     <= S_SCAN;
               end
            end

            S_SCAN: begin
               if (!w_byte_ok) begin
                  if (r_key == KEY_LAST) begin
                     r_key_valid <= 1'b0;
                     r_rdy       <= 1'b1;
                     r_state     <= S_IDLE;
                  end else begin
                     r_key   <= r_key + KEY_STEP;
                     r_state <= S_LAUNCH;
                  end
               end else if (r_idx == r_len) begin
                  r_key_valid <= 1'b1;
                  r_rdy       <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_idx <= r_idx + 8'd1;
                  // stop issuing at len so a 255-byte message never wraps to 0
                  if (r_scan_addr != r_len) begin
                     r_scan_addr <= r_scan_addr + 8'd1;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_crack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crack_ctrl
//  Purpose  : Self-checking bench for crack_ctrl. Two instances share one
//             arc4 stub and one pt_mem model: instance A searches keys
//             0x00..0x3F, instance B has a single key 0x10.
//  Revision : 1.0  initial release
// ============================================================================
module tb_crack_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, en_a, en_b, sel;
   logic        a_rdy, a_key_valid, a_a4_en, a_pt_wren;
   logic [23:0] a_key;
   logic [7:0]  a_pt_addr, a_pt_wrdata;
   logic        b_rdy, b_key_valid, b_a4_en, b_pt_wren;
   logic [23:0] b_key;
   logic [7:0]  b_pt_addr, b_pt_wrdata;

   // arc4 stub and memory
   logic        s_rdy, s_busy, s_wait, s_fin, s_wren;
   logic [7:0]  s_idx, s_data, pt_rddata;
   logic [5:0]  s_key;
   logic [7:0]  msg [0:63][0:255];
   logic [7:0]  mem [0:255];
   logic        m_a4_en, m_wren;
   logic [23:0] m_key;
   logic [7:0]  m_addr, m_wrdata;

   int pa = 0;
   int pb = 0;
   int errors = 0;
   int checks = 0;

   crack_ctrl #(
      .KEY_W(24), .KEY_FIRST(24'h000000), .KEY_STEP(24'h000001), .KEY_LAST(24'h00003F),
      .CH_LO(8'h20), .CH_HI(8'h7E)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .rdy(a_rdy), .key(a_key), .key_valid(a_key_valid),
      .a4_en(a_a4_en), .a4_rdy(s_rdy), .a4_pt_addr(s_idx), .a4_pt_wrdata(s_data),
      .a4_pt_wren(s_wren), .pt_addr(a_pt_addr), .pt_wrdata(a_pt_wrdata), .pt_wren(a_pt_wren),
      .pt_rddata(pt_rddata)
   );

   crack_ctrl #(
      .KEY_W(24), .KEY_FIRST(24'h000010), .KEY_STEP(24'h000001), .KEY_LAST(24'h000010),
      .CH_LO(8'h20), .CH_HI(8'h7E)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .rdy(b_rdy), .key(b_key), .key_valid(b_key_valid),
      .a4_en(b_a4_en), .a4_rdy(s_rdy), .a4_pt_addr(s_idx), .a4_pt_wrdata(s_data),
      .a4_pt_wren(s_wren), .pt_addr(b_pt_addr), .pt_wrdata(b_pt_wrdata), .pt_wren(b_pt_wren),
      .pt_rddata(pt_rddata)
   );

   assign m_a4_en  = sel ? b_a4_en     : a_a4_en;
   assign m_key    = sel ? b_key       : a_key;
   assign m_addr   = sel ? b_pt_addr   : a_pt_addr;
   assign m_wrdata = sel ? b_pt_wrdata : a_pt_wrdata;
   assign m_wren   = sel ? b_pt_wren   : a_pt_wren;
   assign s_wren   = s_busy && !s_wait;
   assign s_data   = msg[s_key][s_idx];

   // Stub arc4: rdy stays high one cycle after en, then writes msg[key][0..len]
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_rdy <= 1'b1; s_busy <= 1'b0; s_wait <= 1'b0; s_fin <= 1'b0;
         s_idx <= 8'd0; s_key <= 6'd0;
      end else if (!s_busy) begin
         if (m_a4_en) begin
            s_busy <= 1'b1; s_wait <= 1'b1; s_idx <= 8'd0;
            s_key <= m_key[5:0]; s_fin <= 1'b0;
         end
      end else if (s_wait) begin
         s_wait <= 1'b0; s_rdy <= 1'b0;
      end else if (s_idx == msg[s_key][0]) begin
         s_busy <= 1'b0; s_rdy <= 1'b1; s_fin <= 1'b1;
      end else begin
         s_idx <= s_idx + 8'd1;
      end
   end

   always @(posedge clk) begin
      if (m_wren) mem[m_addr] <= m_wrdata;
      pt_rddata <= mem[m_addr];
   end

   always @(posedge clk) begin
      if (a_a4_en) pa <= pa + 1;
      if (b_a4_en) pb <= pb + 1;
   end

   // ---------------------------------------------------------------- model
   function automatic bit byte_ok(input logic [7:0] b);
      return (b >= 8'd32) && (b <= 8'd126);
   endfunction

   function automatic bit msg_ok(input int k);
      for (int i = 1; i <= int'(msg[k][0]); i++)
         if (!byte_ok(msg[k][i])) return 1'b0;
      return 1'b1;
   endfunction

   // Walk keys first, first+step, ... until a printable message or last.
   task automatic model_search(input int first, input int step, input int last,
                               output logic [23:0] k_out, output bit v_out, output int p_out);
      int k;
      k = first; p_out = 0; v_out = 1'b0; k_out = 24'(first);
      for (int n = 0; n < 1000; n++) begin
         p_out++;
         k_out = 24'(k);
         if (msg_ok(k % 64)) begin v_out = 1'b1; return; end
         if (k == last) begin v_out = 1'b0; return; end
         k = k + step;
      end
   endtask

   task automatic fill_print(input int k, input int len);
      msg[k][0] = 8'(len);
      for (int i = 1; i <= len; i++) begin
         case ($urandom_range(0, 5))
            0:       msg[k][i] = 8'h20;
            1:       msg[k][i] = 8'h7E;
            default: msg[k][i] = 8'($urandom_range(32, 126));
         endcase
      end
   endtask

   task automatic fill_fail(input int k, input int len);
      int pos;
      fill_print(k, len);
      pos = $urandom_range(1, len);
      msg[k][pos] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31))
                                                 : 8'($urandom_range(127, 255));
   endtask

   task automatic fill_directed();
      for (int k = 0; k < 64; k++) fill_fail(k, 4);
      for (int k = 0; k < 3; k++) begin msg[k][0] = 8'd1; msg[k][1] = 8'h07; end
      msg[3][0] = 8'd3; msg[3][1] = "H"; msg[3][2] = "i"; msg[3][3] = "!";
   endtask

   // Pulse en for one cycle, wait for rdy with a cycle budget.
   task automatic start_and_wait(input bit use_b, input int budget,
                                 output bit dropped, output bit timeout, output int pulses);
      int base;
      base = use_b ? pb : pa;
      @(negedge clk);
      if (use_b) en_b = 1'b1; else en_a = 1'b1;
      @(negedge clk);
      en_a = 1'b0; en_b = 1'b0;
      dropped = use_b ? !b_rdy : !a_rdy;
      timeout = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if ((use_b ? b_rdy : a_rdy) === 1'b1) begin timeout = 1'b0; break; end
         @(negedge clk);
      end
      pulses = (use_b ? pb : pa) - base;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; sel = 1'b0;
      #12;
      checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", a_rdy); end
      checks++; if (a_key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_key_valid); end
      checks++; if (a_key !== 24'h0) begin errors++; $display("FAIL reset_key: got %h want 000000", a_key); end
      checks++; if (a_a4_en !== 1'b0) begin errors++; $display("FAIL reset_a4_en: got %b want 0", a_a4_en); end
      checks++; if (a_pt_addr !== 8'h0) begin errors++; $display("FAIL reset_pt_addr: got %h want 00", a_pt_addr); end
      checks++; if (a_pt_wren !== 1'b0) begin errors++; $display("FAIL reset_pt_wren: got %b want 0", a_pt_wren); end
      checks++; if (b_key !== 24'h10) begin errors++; $display("FAIL reset_key_b: got %h want 000010", b_key); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_and_check(input string name);
      logic [23:0] ek; bit ev; int ep; bit dr, to; int p;
      model_search(0, 1, 63, ek, ev, ep);
      start_and_wait(1'b0, 20000, dr, to, p);
      checks++; if (!dr) begin errors++; $display("FAIL %s_rdy_drop: rdy still 1 one cycle after en", name); end
      checks++; if (to) begin errors++; $display("FAIL %s_timeout: rdy never returned", name); end
      checks++; if (a_key !== ek) begin errors++; $display("FAIL %s_key: got %h want %h", name, a_key, ek); end
      checks++; if (a_key_valid !== ev) begin errors++; $display("FAIL %s_valid: got %b want %b", name, a_key_valid, ev); end
      checks++; if (p != ep) begin errors++; $display("FAIL %s_pulses: got %0d want %0d", name, p, ep); end
   endtask

   task automatic test_directed();
      fill_directed();
      run_and_check("hi");
   endtask

   task automatic test_random();
      int t;
      for (int trial = 0; trial < 4; trial++) begin
         t = $urandom_range(0, 20);
         for (int k = 0; k < 64; k++) begin
            if (k < t) fill_fail(k, $urandom_range(1, 12));
            else if (k == t) fill_print(k, $urandom_range(0, 12));
            else if ($urandom_range(0, 1) == 0) fill_print(k, $urandom_range(0, 12));
            else fill_fail(k, $urandom_range(1, 12));
         end
         run_and_check("random");
      end
   endtask

   task automatic test_boundary();
      for (int k = 0; k < 64; k++) fill_fail(k, 3);
      msg[0][0] = 8'd2; msg[0][1] = 8'h20; msg[0][2] = 8'h1F;
      msg[1][0] = 8'd2; msg[1][1] = 8'h7F; msg[1][2] = 8'h20;
      msg[2][0] = 8'd2; msg[2][1] = 8'h20; msg[2][2] = 8'h7E;
      run_and_check("chars");
      msg[0][0] = 8'd0;
      run_and_check("len0");
   endtask

   task automatic test_len255();
      int base, cnt, bad, nseen;
      bit seen [0:255];
      fill_print(0, 255);
      msg[0][1] = 8'h20; msg[0][255] = 8'h7E;
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      base = pa; cnt = 0; bad = 0; nseen = 0;
      @(negedge clk); en_a = 1'b1;
      @(negedge clk); en_a = 1'b0;
      for (int c = 0; c < 3000 && !a_rdy; c++) begin
         if (pa > base && s_fin) begin
            cnt++; seen[a_pt_addr] = 1'b1;
            if (a_pt_wren) bad++;
         end
         @(negedge clk);
      end
      for (int i = 1; i < 256; i++) if (seen[i]) nseen++;
      checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL len255_timeout: rdy=%b want 1", a_rdy); end
      checks++; if (a_key !== 24'h0 || a_key_valid !== 1'b1) begin errors++; $display("FAIL len255_result: got key %h valid %b want 000000 1", a_key, a_key_valid); end
      // the cycle arc4 reports ready, then 2 + n scanner cycles
      checks++; if (cnt != 1 + 2 + 255) begin errors++; $display("FAIL len255_latency: got %0d want %0d", cnt, 258); end
      checks++; if (nseen != 255) begin errors++; $display("FAIL len255_addrs: got %0d distinct want 255", nseen); end
      checks++; if (bad != 0) begin errors++; $display("FAIL len255_wren: got %0d write cycles want 0", bad); end
   endtask

   task automatic test_exhaust();
      bit dr, to; int p;
      for (int k = 0; k < 64; k++) fill_fail(k, $urandom_range(1, 8));
      run_and_check("exhaust");
      msg[16][0] = 8'd3; msg[16][1] = "a"; msg[16][2] = 8'h7F; msg[16][3] = "b";
      sel = 1'b1;
      start_and_wait(1'b1, 2000, dr, to, p);
      sel = 1'b0;
      checks++; if (to || b_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b want 1", b_rdy); end
      checks++; if (p != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", p); end
      checks++; if (b_key_valid !== 1'b0) begin errors++; $display("FAIL single_valid: got %b want 0", b_key_valid); end
      checks++; if (b_key !== 24'h10) begin errors++; $display("FAIL single_key: got %h want 000010", b_key); end
   endtask

   task automatic check_async_reset(input string name);
      rst_n = 1'b0;
      #1;
      checks++; if (a_rdy !== 1'b1 || a_key_valid !== 1'b0) begin errors++; $display("FAIL %s_flags: got rdy %b valid %b want 1 0", name, a_rdy, a_key_valid); end
      checks++; if (a_key !== 24'h0) begin errors++; $display("FAIL %s_key: got %h want 000000", name, a_key); end
      checks++; if (a_pt_wren !== 1'b0 || a_a4_en !== 1'b0) begin errors++; $display("FAIL %s_wren: got wren %b a4_en %b want 0 0", name, a_pt_wren, a_a4_en); end
      checks++; if (a_pt_addr !== 8'h0) begin errors++; $display("FAIL %s_addr: got %h want 00", name, a_pt_addr); end
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int base;
      fill_directed();
      // during RUN while arc4 is writing key 2's plaintext
      base = pa;
      @(negedge clk); en_a = 1'b1;
      @(negedge clk); en_a = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (pa - base == 3 && s_busy && !s_wait) break;
         @(negedge clk);
      end
      checks++; if (a_pt_wren !== 1'b1) begin errors++; $display("FAIL run_pre_wren: got %b want 1", a_pt_wren); end
      check_async_reset("rst_run");
      run_and_check("after_rst_run");
      // during the scan of key 1
      base = pa;
      @(negedge clk); en_a = 1'b1;
      @(negedge clk); en_a = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (pa - base == 2 && s_fin) break;
         @(negedge clk);
      end
      @(negedge clk); @(negedge clk);
      checks++; if (a_rdy !== 1'b0 || a_key !== 24'h1) begin errors++; $display("FAIL scan_pre: got rdy %b key %h want 0 000001", a_rdy, a_key); end
      check_async_reset("rst_scan");
      run_and_check("after_rst_scan");
   endtask

   task automatic test_en_held();
      int base; bit ok;
      fill_directed();
      base = pa; ok = 1'b0;
      @(negedge clk); en_a = 1'b1;
      for (int c = 0; c < 100 && a_rdy; c++) @(negedge clk);
      for (int c = 0; c < 5000; c++) begin
         if (a_rdy) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checks++; if (!ok) begin errors++; $display("FAIL held_timeout: rdy never returned"); end
      checks++; if (pa - base != 4) begin errors++; $display("FAIL held_pulses: got %0d want 4", pa - base); end
      checks++; if (a_key !== 24'h3 || a_key_valid !== 1'b1) begin errors++; $display("FAIL held_result: got key %h valid %b want 000003 1", a_key, a_key_valid); end
      @(negedge clk);
      checks++; if (a_rdy !== 1'b0 || a_key_valid !== 1'b0 || a_key !== 24'h0) begin errors++; $display("FAIL held_restart: got rdy %b valid %b key %h want 0 0 000000", a_rdy, a_key_valid, a_key); end
      en_a = 1'b0; ok = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         if (a_rdy) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checks++; if (!ok || pa - base != 8 || a_key !== 24'h3 || a_key_valid !== 1'b1) begin errors++; $display("FAIL held_second: got rdy %b pulses %0d key %h valid %b want 1 8 000003 1", a_rdy, pa - base, a_key, a_key_valid); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_boundary();
      test_len255();
      test_exhaust();
      test_reset_mid();
      test_en_held();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
